rr_mux_reg: RTL

- Parametrised N-input, W-bit arbitrating multiplexer with a registered output stage and valid/ready handshakes on every channel.
- Generalises the fixed 2:1 and 3:1 combinational datapath muxes.
- Select is internal: an arbiter picks one requesting channel per cycle, by round-robin by default.
- Used where several pipeline sources share one sink, e.g. writeback/forwarding sources or memory request ports.

---
 rtl/rr_mux_reg_if.sv | 26 ++
 rtl/rr_mux_reg.sv | 93 +++++++++
 2 files changed

// File: rtl/rr_mux_reg_if.sv
// rr_mux_reg_if: N-channel valid/ready input bundle plus registered output channel
interface rr_mux_reg_if #(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int SW = $clog2(N)
);
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_sel;

    // Sources and sink drive this side
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sel
    );

    // The arbitrating mux sits on this side
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sel
    );
endinterface

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N:1 arbitrating mux with registered output; RR_MUX_FIXED_PRIO_EN selects fixed priority
module rr_mux_reg #(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    rr_mux_reg_if.slave  bus
);
    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] out_sel_q, out_sel_d;
    logic [SW-1:0] g;
    logic          any_v;
    logic          load;

    assign any_v = |bus.in_valid;
    assign load  = !out_valid_q || bus.out_ready;

`ifdef RR_MUX_FIXED_PRIO_EN
    // Fixed priority: the lowest requesting index wins
    always_comb begin
        g = '0;
        for (int k = N - 1; k >= 0; k--)
            if (bus.in_valid[k]) g = SW'(k);
    end
`else
    logic [SW-1:0] ptr_q, ptr_d;
    logic [SW:0]   s;
    logic          found;

    // Round-robin: first requester scanning upward from ptr, wrapping at N
    always_comb begin
        g = '0;
        found = 1'b0;
        s = '0;
        for (int k = 0; k < N; k++) begin
            s = {1'b0, ptr_q} + (SW+1)'(k);
            if (s >= (SW+1)'(N)) s = s - (SW+1)'(N);
            if (!found && bus.in_valid[s[SW-1:0]]) begin
                g = s[SW-1:0];
                found = 1'b1;
            end
        end
    end

    // Pointer moves past the winner only when a beat is actually taken
    always_comb begin
        ptr_d = ptr_q;
        if (load && any_v) ptr_d = (g == SW'(N - 1)) ? '0 : g + 1'b1;
    end

    // Pointer register; reset restarts arbitration from channel 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`endif

    // Output stage next state: refill when empty or draining, hold when stalled
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            out_valid_d = any_v;
            if (any_v) begin
                out_data_d = bus.in_data[int'(g)*W +: W];
                out_sel_d  = g;
            end
        end
    end

    // Output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    // Grant is forced off during reset since the registers alone would report load=1
    assign bus.in_ready  = (!rst && load && any_v) ? N'(1) << g : '0;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sel   = out_sel_q;
endmodule
